dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the single-port data memory between the pipeline's MEM stage (CPU port) and a debug/loader port (DBG port). Grants one access at a time and tracks the outstanding read for the configured memory latency. Returns read data with a per-port valid strobe and raises a stall to the pipeline while the CPU request waits. Sits between the MEM stage and the data memory, on the address, write-data, write-enable and read-data paths.

## Interface
- `ADDR_W`, default 32: address width.
- `WDATA_W`, default 32: write-data width.
- `RDATA_W`, default 8: read-data width, matching the memory's byte read port.
- `MEM_LAT`, default 1: cycles from read grant to read data valid at `mem_rdata_i`; legal range 1..15.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `cpu_req_i` in 1: CPU access request.
- `cpu_we_i` in 1: CPU access is a write (1) or a read (0).
- `cpu_addr_i` in ADDR_W: CPU address.
- `cpu_wdata_i` in WDATA_W: CPU write data.
- `cpu_gnt_o` out 1: CPU access accepted this cycle.
- `cpu_rvalid_o` out 1: CPU read data valid this cycle.
- `dbg_req_i`, `dbg_we_i`, `dbg_addr_i`, `dbg_wdata_i`, `dbg_gnt_o`, `dbg_rvalid_o`: same meaning and widths as the CPU set, for the DBG port.
- `rdata_o` out RDATA_W: shared read data; meaningful only when an `*_rvalid_o` is high.
- `mem_addr_o` out ADDR_W: memory address.
- `mem_wdata_o` out WDATA_W: memory write data.
- `mem_we_o` out 1: memory write enable.
- `mem_rdata_i` in RDATA_W: memory read data.
- `stall_o` out 1: pipeline stall request.

## Operation
- States:
  - IDLE: port free.
  - BUSY: read outstanding; 4-bit down-counter `lat_cnt`.
- Grant, IDLE only:
  - If any request is present, exactly one gnt goes high, chosen by the arbitration policy (see Configuration).
  - The granted port's addr and wdata drive `mem_addr_o` and `mem_wdata_o`.
  - `mem_we_o` = granted we.
- Grant of a write: the write completes in the grant cycle, no rvalid is produced, and the state stays IDLE.
- Grant of a read:
  - Go to BUSY with `lat_cnt` = MEM_LAT-1 and record the owner (CPU or DBG).
  - When MEM_LAT=1 the read completes on the next cycle with the counter already at 0.
- BUSY:
  - No grants; `mem_we_o` = 0.
  - `lat_cnt` decrements each cycle.
  - In the cycle `lat_cnt` = 0, the owner's rvalid goes high, `rdata_o` = `mem_rdata_i`, and the state returns to IDLE.
  - That completion cycle is also treated as IDLE for granting, so a new grant can issue back-to-back in the same cycle.
- Idle bus: with no grant, `mem_addr_o`/`mem_wdata_o` = 0 and `mem_we_o` = 0.
- Requester rules:
  - Hold req, we, addr and wdata stable until gnt.
  - The cycle after gnt, present the next request or drop req.
  - Inputs may change freely while req=0.
- `stall_o` = `cpu_req_i` & ~`cpu_gnt_o`.
- Reset: all outputs 0, state IDLE, `lat_cnt` = 0, `last_gnt` = DBG, so the CPU wins the first tie. Reset asserted mid-read aborts the read; no rvalid is ever produced for it.

## Timing
- gnt, `mem_*` outputs and `stall_o` are combinational from the requests and current state; no registered delay.
- rvalid: exactly MEM_LAT cycles after the read-grant edge; one-cycle pulse.
- Read throughput: one read per MEM_LAT cycles. Write throughput: one per cycle while IDLE.
- Simultaneous requests: exactly one gnt; the loser's req stays pending.

## Configuration
- `DMEM_ARB_RR_EN` defined:
  - Round-robin arbitration. On a tie, the port not in `last_gnt` wins.
  - `last_gnt` updates on every grant.
  - No port waits for more than one other grant.
- `DMEM_ARB_RR_EN` undefined:
  - Fixed priority, CPU over DBG; `last_gnt` logic is removed.
  - DBG is granted only when `cpu_req_i` = 0.

## Test plan
- Reset, then a single CPU read at addr 0x10 with MEM_LAT=1 and mem returning 0xA5:
  - `cpu_gnt_o` is high in cycle 0.
  - `cpu_rvalid_o` and `rdata_o`=0xA5 appear in cycle 1.
  - `stall_o` stays 0 throughout.
- CPU write (addr 0x20, wdata 0xDEADBEEF) and DBG read (addr 0x30) both requested every cycle, round-robin build:
  - Grants alternate CPU, DBG, CPU, …
  - `stall_o` = 1 in exactly the cycles where the CPU is denied.
- Same traffic as above, fixed-priority build: DBG is never granted while `cpu_req_i` = 1.
- MEM_LAT=3, DBG read granted at cycle 0 with a CPU request arriving at cycle 1:
  - No gnt in cycles 1–2.
  - In cycle 3, `dbg_rvalid_o` is high together with `cpu_gnt_o`.
  - `stall_o` = 1 in cycles 1–2.
- MEM_LAT=2, `rst_ni` pulsed low 1 cycle after a CPU read grant:
  - All outputs drop to 0 immediately.
  - No `cpu_rvalid_o` is ever produced for that read.
  - The next request is granted cleanly.
- Back-to-back CPU reads with MEM_LAT=1 at addrs 0,1,2: grants in cycles 0, 1 and 2; rvalid in cycles 1, 2 and 3, each carrying the matching data.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU (MEM stage) and DBG ports; reads return after MEM_LAT cycles.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise CPU has fixed priority over DBG.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int WDATA_W = 32,
    parameter int RDATA_W = 8,
    parameter int MEM_LAT = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cpu_req_i,
    input  logic               cpu_we_i,
    input  logic [ADDR_W-1:0]  cpu_addr_i,
    input  logic [WDATA_W-1:0] cpu_wdata_i,
    output logic               cpu_gnt_o,
    output logic               cpu_rvalid_o,
    input  logic               dbg_req_i,
    input  logic               dbg_we_i,
    input  logic [ADDR_W-1:0]  dbg_addr_i,
    input  logic [WDATA_W-1:0] dbg_wdata_i,
    output logic               dbg_gnt_o,
    output logic               dbg_rvalid_o,
    output logic [RDATA_W-1:0] rdata_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [WDATA_W-1:0] mem_wdata_o,
    output logic               mem_we_o,
    input  logic [RDATA_W-1:0] mem_rdata_i,
    output logic               stall_o
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_lat_cnt, w_lat_cnt_nxt;
    logic       r_owner_dbg, w_owner_dbg_nxt;
    logic       w_cpu_req, w_dbg_req, w_done, w_can_gnt;
    logic       w_cpu_gnt, w_dbg_gnt, w_gnt_we;

    // Requests are masked during reset so every output reads 0 while rst_ni is low.
    assign w_cpu_req = cpu_req_i & rst_ni;
    assign w_dbg_req = dbg_req_i & rst_ni;
    assign w_done    = (r_state == BUSY) && (r_lat_cnt == 4'd0);
    assign w_can_gnt = (r_state == IDLE) || w_done;

`ifdef DMEM_ARB_RR_EN
    logic r_last_dbg;

    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dbg_gnt = 1'b0;
        if (w_can_gnt) begin
            if (w_cpu_req && w_dbg_req) begin
                w_cpu_gnt = r_last_dbg;
                w_dbg_gnt = ~r_last_dbg;
            end else begin
                w_cpu_gnt = w_cpu_req;
                w_dbg_gnt = w_dbg_req;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last_dbg <= 1'b1;
        end else if (w_cpu_gnt || w_dbg_gnt) begin
            r_last_dbg <= w_dbg_gnt;
        end
    end
`else
    assign w_cpu_gnt = w_can_gnt & w_cpu_req;
    assign w_dbg_gnt = w_can_gnt & w_dbg_req & ~w_cpu_req;
`endif

    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        w_gnt_we    = 1'b0;
        if (w_cpu_gnt) begin
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
            w_gnt_we    = cpu_we_i;
        end else if (w_dbg_gnt) begin
            mem_addr_o  = dbg_addr_i;
            mem_wdata_o = dbg_wdata_i;
            w_gnt_we    = dbg_we_i;
        end
    end

    // A read granted in the completion cycle re-arms the counter immediately.
    always_comb begin
        w_state_nxt     = r_state;
        w_lat_cnt_nxt   = r_lat_cnt;
        w_owner_dbg_nxt = r_owner_dbg;
        if ((w_cpu_gnt || w_dbg_gnt) && !w_gnt_we) begin
            w_state_nxt     = BUSY;
            w_lat_cnt_nxt   = LAT_INIT;
            w_owner_dbg_nxt = w_dbg_gnt;
        end else if (w_done) begin
            w_state_nxt = IDLE;
        end else if (r_state == BUSY) begin
            w_lat_cnt_nxt = r_lat_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_lat_cnt   <= 4'd0;
            r_owner_dbg <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lat_cnt   <= w_lat_cnt_nxt;
            r_owner_dbg <= w_owner_dbg_nxt;
        end
    end

    assign cpu_gnt_o    = w_cpu_gnt;
    assign dbg_gnt_o    = w_dbg_gnt;
    assign mem_we_o     = w_gnt_we;
    assign cpu_rvalid_o = w_done & ~r_owner_dbg;
    assign dbg_rvalid_o = w_done & r_owner_dbg;
    assign rdata_o      = w_done ? mem_rdata_i : '0;
    assign stall_o      = w_cpu_req & ~w_cpu_gnt;

endmodule
